// File: rtl/kernel3_gmem_a_m_axi_srl_fifo.sv
// kernel3 gmem_A m_axi FIFO: shift-register store + registered FWFT output.
// Holds DEPTH words: DEPTH-1 in the shift store, one in the output stage.
module kernel3_gmem_a_m_axi_srl_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   num_data_valid
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-2];
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;
    logic                  dout_vld;
    logic                  dout_vld_next;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  push;
    logic                  pop;
    logic                  take;

    // full_n is registered, so a same-cycle pop never admits a push when full
    assign push  = if_write_ce & if_write & if_full_n;
    assign pop   = if_read_ce & (cnt != '0) & (~dout_vld | if_read);
    assign take  = if_read_ce & if_read & dout_vld;
    assign raddr = ADDR_WIDTH'(cnt - CW'(1));

    assign if_empty_n = dout_vld;

    // next occupancy of the shift store and of the output stage
    always_comb begin
        cnt_next      = cnt + CW'(push) - CW'(pop);
        dout_vld_next = dout_vld;
        if (pop) begin
            dout_vld_next = 1'b1;
        end else if (take) begin
            dout_vld_next = 1'b0;
        end
    end

    // shift store: newest word enters at index 0, contents never reset
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = DEPTH - 2; i > 0; i--) begin
                mem[i] <= mem[i-1];
            end
            mem[0] <= if_din;
        end
    end

    // occupancy counter and registered status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= '0;
            dout_vld       <= 1'b0;
            if_full_n      <= 1'b1;
            num_data_valid <= '0;
        end else begin
            cnt            <= cnt_next;
            dout_vld       <= dout_vld_next;
            if_full_n      <= (cnt_next != CNT_MAX);
            num_data_valid <= cnt_next + CW'(dout_vld_next);
        end
    end

    // output stage: oldest stored word, read before this edge's shift
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_dout <= '0;
        end else if (pop) begin
            if_dout <= mem[raddr];
        end
    end

endmodule

// File: tb/tb_kernel3_gmem_a_m_axi_srl_fifo.sv
// Bench for kernel3_gmem_a_m_axi_srl_fifo: queue scoreboard + occupancy model.
// Stimulus issues writes/reads; a negedge monitor checks every output.
module tb_kernel3_gmem_a_m_axi_srl_fifo;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          if_full_n;
    logic          if_write_ce = 1'b0;
    logic          if_write = 1'b0;
    logic [DW-1:0] if_din = '0;
    logic          if_empty_n;
    logic          if_read_ce = 1'b0;
    logic          if_read = 1'b0;
    logic [DW-1:0] if_dout;
    logic [AW:0]   num_data_valid;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q [$];
    int            occ;
    bit            vis;
    logic [DW-1:0] last_dout;
    logic [DW-1:0] e_dout;
    bit            mon_en = 1'b0;

    always #5 clk = ~clk;

    kernel3_gmem_a_m_axi_srl_fifo #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .if_full_n(if_full_n),
        .if_write_ce(if_write_ce),
        .if_write(if_write),
        .if_din(if_din),
        .if_empty_n(if_empty_n),
        .if_read_ce(if_read_ce),
        .if_read(if_read),
        .if_dout(if_dout),
        .num_data_valid(num_data_valid)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        occ       = 0;
        vis       = 1'b0;
        last_dout = '0;
        exp_q.delete();
    endtask

    // FIFO seen as: occ words total, head visible or not
    task automatic model_step();
        int store;
        bit push;
        bit pop;
        bit took;
        store = occ - int'(vis);
        push  = if_write_ce && if_write && (store != DEPTH - 1);
        took  = if_read_ce && if_read && vis;
        pop   = if_read_ce && (store != 0) && (!vis || if_read);
        if (push) begin
            exp_q.push_back(if_din);
            occ++;
        end
        if (took) occ--;
        if (pop) vis = 1'b1;
        else if (took) vis = 1'b0;
    endtask

    task automatic cycle(input bit w, input logic [DW-1:0] d, input bit wce,
                         input bit r, input bit rce);
        if_write    = w;
        if_din      = d;
        if_write_ce = wce;
        if_read     = r;
        if_read_ce  = rce;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    endtask

    // monitor: compare flags, count and head word; pop on consumption
    always @(negedge clk) begin
        if (reset_n && mon_en) begin
            chk("full_n", if_full_n, (occ - int'(vis)) != DEPTH - 1);
            chk("empty_n", if_empty_n, vis);
            chk("count", num_data_valid, occ);
            e_dout = (vis && exp_q.size() > 0) ? exp_q[0] : last_dout;
            chk("dout", if_dout, e_dout);
            if (vis) last_dout = e_dout;
            if (vis && if_read && if_read_ce && exp_q.size() > 0)
                void'(exp_q.pop_front());
        end
    end

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        #2;
        chk("rst_full_n", if_full_n, 1);
        chk("rst_empty_n", if_empty_n, 0);
        chk("rst_dout", if_dout, 0);
        chk("rst_count", num_data_valid, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        mon_en = 1'b1;
        idle(3);

        // single word, held without reads
        cycle(1'b1, 32'h11, 1'b1, 1'b0, 1'b1);
        idle(1);
        chk("one_empty_n", if_empty_n, 1);
        chk("one_dout", if_dout, 32'h11);
        chk("one_count", num_data_valid, 1);
        idle(10);
        chk("one_hold", if_dout, 32'h11);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        idle(2);

        // fill to capacity, extra write dropped
        for (int i = 1; i <= DEPTH; i++)
            cycle(1'b1, DW'(i), 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'hFF, 1'b1, 1'b0, 1'b1);
        idle(2);
        chk("fill_count", num_data_valid, DEPTH);
        chk("fill_full_n", if_full_n, 0);
        chk("fill_head", if_dout, 32'h1);

        // write+read while full: write rejected
        cycle(1'b1, 32'hAA, 1'b1, 1'b1, 1'b1);
        chk("full_rw_count", num_data_valid, DEPTH - 1);
        chk("full_rw_full_n", if_full_n, 1);
        chk("full_rw_head", if_dout, 32'h2);
        repeat (DEPTH + 4) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // read_ce low freezes read side, writes continue
        repeat (4) cycle(1'b1, $urandom, 1'b1, 1'b0, 1'b1);
        idle(3);
        repeat (5) cycle(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
        chk("rce_count", num_data_valid, 9);
        repeat (3) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
        chk("wce_count", num_data_valid, 9);
        repeat (12) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // streaming 0..999 with read held high
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1, DW'(i), 1'b1, 1'b1, 1'b1);
            if (i >= 2)
                chk("stream_level",
                    (num_data_valid == 1 || num_data_valid == 2), 1);
        end
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("stream_drained", num_data_valid, 0);

        // random traffic, alternating fill-biased and drain-biased phases
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 400; i++) begin
                bit w;
                bit r;
                w = ($urandom_range(0, 3) != 0) ^ p[0];
                r = ($urandom_range(0, 3) == 0) ^ p[0];
                cycle(w, $urandom, $urandom_range(0, 7) != 0,
                      r, $urandom_range(0, 7) != 0);
            end
        end

        // async reset mid-cycle with data in flight
        repeat (20) cycle(1'b1, $urandom, 1'b1, 1'b0, 1'b1);
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("arst_full_n", if_full_n, 1);
        chk("arst_empty_n", if_empty_n, 0);
        chk("arst_dout", if_dout, 0);
        chk("arst_count", num_data_valid, 0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        mon_en = 1'b1;
        cycle(1'b1, 32'h5A5A_0001, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h5A5A_0002, 1'b1, 1'b0, 1'b1);
        idle(2);
        chk("post_rst_head", if_dout, 32'h5A5A_0001);
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
